// File: rtl/weight_buf_pkg.sv
// Shared types and sizes for the 3x3 kernel weight buffer and the row-rotation stage.
// No logic; constants and the cal_state encoding only.
// Row index wraps modulo KDIM; the encoding value 3 is never produced.
package weight_buf_pkg;

    localparam int DATA_W = 16;
    localparam int KDIM   = 3;
    localparam int KWORDS = KDIM * KDIM;
    localparam int KWIDTH = KWORDS * DATA_W;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        CAL_R0 = 2'd0,
        CAL_R1 = 2'd1,
        CAL_R2 = 2'd2
    } cal_state_t;

    // Next row-rotation index; anything unexpected falls back to row 0.
    function automatic cal_state_t cal_next(input cal_state_t s);
        case (s)
            CAL_R0:  return CAL_R1;
            CAL_R1:  return CAL_R2;
            default: return CAL_R0;
        endcase
    endfunction

endpackage

// File: rtl/weight_shadow_loader.sv
// Assembles nine weight words into the shadow bank, row-major, word k at bits [16k+15:16k].
// Latency: a word lands in the shadow one cycle after its handshake; shadow_full follows word 8.
// Backpressure: w_ready drops while the shadow is full and rises the cycle after it is drained.
module weight_shadow_loader
    import weight_buf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_valid,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_ready,
    input  logic              drain,
    output logic [KWIDTH-1:0] shadow,
    output logic              shadow_full
);

    logic [CNT_W-1:0] word_cnt;
    logic             take_vld;

    assign w_ready  = !shadow_full;
    assign take_vld = w_valid && !shadow_full;

    // Word counter, shadow storage and full flag; drain and take never coincide
    // because a drain needs a full shadow and a take needs an empty one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_cnt    <= '0;
            shadow      <= '0;
            shadow_full <= 1'b0;
        end else begin
            if (drain) begin
                shadow_full <= 1'b0;
            end
            if (take_vld) begin
                for (int k = 0; k < KWORDS; k++) begin
                    if (word_cnt == CNT_W'(k)) begin
                        shadow[k*DATA_W +: DATA_W] <= w_data;
                    end
                end
                if (word_cnt == CNT_W'(KWORDS - 1)) begin
                    word_cnt    <= '0;
                    shadow_full <= 1'b1;
                end else begin
                    word_cnt <= word_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/weight_buffer.sv
// Double-buffered 3x3 kernel store feeding the PE row-rotation stage; optional WEIGHT_BUF_SWAP_CNT_EN adds swap_cnt/underrun.
// Latency: swap to new weight_out is 1 cycle with a full shadow; an early swap completes the cycle after word 8 lands.
// Backpressure: w_ready low while the shadow holds an unswapped kernel; extra swaps while pending are absorbed.
module weight_buffer
    import weight_buf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_valid,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_ready,
    input  logic              swap,
    input  logic              row_advance,
    output logic [KWIDTH-1:0] weight_out,
    output logic [1:0]        cal_state,
    output logic              weight_valid,
    output logic              swap_pending
`ifdef WEIGHT_BUF_SWAP_CNT_EN
    ,
    output logic [15:0]       swap_cnt,
    output logic              underrun
`endif
);

    logic [KWIDTH-1:0] shadow;
    logic              shadow_full;
    logic              swap_exec;
    cal_state_t        cal_q;

    // A swap fires once the shadow is complete, whether requested now or earlier.
    assign swap_exec = (swap || swap_pending) && shadow_full;
    assign cal_state = cal_q;

    weight_shadow_loader u_loader (
        .clk         (clk),
        .rst_n       (rst_n),
        .w_valid     (w_valid),
        .w_data      (w_data),
        .w_ready     (w_ready),
        .drain       (swap_exec),
        .shadow      (shadow),
        .shadow_full (shadow_full)
    );

    // Active bank, pending-swap flag and row rotation; a swap overrides row_advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            weight_out   <= '0;
            weight_valid <= 1'b0;
            swap_pending <= 1'b0;
            cal_q        <= CAL_R0;
        end else if (swap_exec) begin
            weight_out   <= shadow;
            weight_valid <= 1'b1;
            swap_pending <= 1'b0;
            cal_q        <= CAL_R0;
        end else begin
            if (swap) begin
                swap_pending <= 1'b1;
            end
            if (row_advance && weight_valid) begin
                cal_q <= cal_next(cal_q);
            end
        end
    end

`ifdef WEIGHT_BUF_SWAP_CNT_EN
    // Saturating count of executed swaps and a one-cycle flag for swaps landing on a pending one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            swap_cnt <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= swap && swap_pending;
            if (swap_exec && (swap_cnt != 16'hFFFF)) begin
                swap_cnt <= swap_cnt + 16'd1;
            end
        end
    end
`else
    // Swap accounting is not built in this configuration.
`endif

endmodule
